// File: rtl/fft_mag_sq_feeder_pkg.sv
// Shared spectrum-analyzer types: component widths and the magnitude FIFO entry.
// No logic; widths here must match the square-root unit operand width.
// DW is the unsigned magnitude-squared width and the square-root operand width.
package fft_mag_sq_feeder_pkg;

  localparam int IW   = 16;
  localparam int IDXW = 10;
  localparam int DW   = 2 * IW;

  typedef struct packed {
    logic [DW-1:0]   mag;
    logic [IDXW-1:0] idx;
    logic            last;
  } entry_t;

endpackage

// File: rtl/fft_mag_sq_feeder_if.sv
// Bin stream in, square-root operand/tag/completion out.
// Pure wiring, no latency.
// Input side is valid/ready; square-root side is paced by sqrt_busy_i.
interface fft_mag_sq_feeder_if;
  import fft_mag_sq_feeder_pkg::*;

  logic signed [IW-1:0] s_re_i;
  logic signed [IW-1:0] s_im_i;
  logic [IDXW-1:0]      s_idx_i;
  logic                 s_last_i;
  logic                 s_valid_i;
  logic                 s_ready_o;
  logic [DW-1:0]        sqrt_din_o;
  logic                 sqrt_din_valid_o;
  logic                 sqrt_busy_i;
  logic [IDXW-1:0]      tag_idx_o;
  logic                 tag_last_o;
  logic                 done_o;

  // Producer of bins / consumer of results
  modport master (
    output s_re_i, s_im_i, s_idx_i, s_last_i, s_valid_i, sqrt_busy_i,
    input  s_ready_o, sqrt_din_o, sqrt_din_valid_o, tag_idx_o, tag_last_o, done_o
  );

  // The feeder itself
  modport slave (
    input  s_re_i, s_im_i, s_idx_i, s_last_i, s_valid_i, sqrt_busy_i,
    output s_ready_o, sqrt_din_o, sqrt_din_valid_o, tag_idx_o, tag_last_o, done_o
  );

endinterface

// File: rtl/fft_mag_sq_feeder_sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO with occupancy output.
// Latency: write visible at head the cycle after the write edge.
// Writes when full are dropped (caller flags it); reads when empty are ignored.
module sync_fifo_fwft #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clr,
  input  logic                   i_wr_vld,
  input  logic [W-1:0]           i_wr_dat,
  input  logic                   i_rd_rdy,
  output logic [W-1:0]           o_rd_dat,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          w_wr;
  logic          w_rd;

  assign o_empty  = (r_level == '0);
  assign o_full   = (r_level == LW'(DEPTH));
  assign w_wr     = i_wr_vld && !o_full && !i_clr;
  assign w_rd     = i_rd_rdy && !o_empty && !i_clr;
  assign o_rd_dat = r_mem[r_rptr];
  assign o_level  = r_level;

  // Storage array; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wr_dat;
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/fft_mag_sq_feeder.sv
// Computes re^2+im^2 per FFT bin and feeds it, tagged, to the iterative sqrt unit.
// Latency: 3 cycles input->FIFO, then one issue whenever the sqrt unit is idle.
// s_ready_o drops once FIFO level plus in-flight stages would exceed DEPTH-1; never stalls.
module fft_mag_sq_feeder
  import fft_mag_sq_feeder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fft_mag_sq_feeder_if.slave     bus,
  input  logic                   clr_i,
  output logic                   ovf_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                 r_run;
  logic                 r_s1_vld;
  logic signed [IW-1:0] r_s1_re;
  logic signed [IW-1:0] r_s1_im;
  logic [IDXW-1:0]      r_s1_idx;
  logic                 r_s1_last;
  logic                 r_s2_vld;
  logic signed [DW-1:0] r_s2_rr;
  logic signed [DW-1:0] r_s2_ii;
  logic [IDXW-1:0]      r_s2_idx;
  logic                 r_s2_last;
  logic                 r_s3_vld;
  entry_t               r_s3;
  logic [DW-1:0]        r_din;
  logic                 r_din_vld;
  logic [IDXW-1:0]      r_tag_idx;
  logic                 r_tag_last;
  logic                 r_inflight;
  logic                 r_busy_q;
  logic                 r_done;
  logic                 r_ovf;

  entry_t               w_head;
  logic                 w_empty;
  logic                 w_full;
  logic [LW-1:0]        w_level;
  logic [LW-1:0]        w_occ;
  logic                 w_in_fire;
  logic                 w_fall;
  logic                 w_pop;

  // Counting the three pipeline stages against FIFO space means no write can ever hit a full FIFO
  assign w_occ         = w_level + LW'(r_s1_vld) + LW'(r_s2_vld) + LW'(r_s3_vld);
  assign bus.s_ready_o = r_run && !clr_i && (w_occ <= LW'(DEPTH - 1));
  assign w_in_fire     = bus.s_valid_i && bus.s_ready_o;

  // The fall cycle is reserved so the tags still name the finishing bin while done_o is high
  assign w_fall = r_inflight && r_busy_q && !bus.sqrt_busy_i;
  assign w_pop  = !w_empty && !bus.sqrt_busy_i && !r_din_vld && !clr_i && !w_fall;

  // Ready comes up one cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  // Three-stage square-and-sum pipeline; clr_i drops everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_re   <= '0;
      r_s1_im   <= '0;
      r_s1_idx  <= '0;
      r_s1_last <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s2_rr   <= '0;
      r_s2_ii   <= '0;
      r_s2_idx  <= '0;
      r_s2_last <= 1'b0;
      r_s3_vld  <= 1'b0;
      r_s3      <= '0;
    end else begin
      r_s1_vld <= w_in_fire && !clr_i;
      r_s2_vld <= r_s1_vld && !clr_i;
      r_s3_vld <= r_s2_vld && !clr_i;
      if (w_in_fire) begin
        r_s1_re   <= bus.s_re_i;
        r_s1_im   <= bus.s_im_i;
        r_s1_idx  <= bus.s_idx_i;
        r_s1_last <= bus.s_last_i;
      end
      if (r_s1_vld) begin
        r_s2_rr   <= DW'(r_s1_re) * DW'(r_s1_re);
        r_s2_ii   <= DW'(r_s1_im) * DW'(r_s1_im);
        r_s2_idx  <= r_s1_idx;
        r_s2_last <= r_s1_last;
      end
      if (r_s2_vld) begin
        // Both squares are non-negative and at most 2^(DW-2), so the sum fits in DW bits
        r_s3.mag  <= $unsigned(r_s2_rr) + $unsigned(r_s2_ii);
        r_s3.idx  <= r_s2_idx;
        r_s3.last <= r_s2_last;
      end
    end
  end

  sync_fifo_fwft #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (clr_i),
    .i_wr_vld (r_s3_vld && !clr_i),
    .i_wr_dat (r_s3),
    .i_rd_rdy (w_pop),
    .o_rd_dat (w_head),
    .o_empty  (w_empty),
    .o_full   (w_full),
    .o_level  (w_level)
  );

  // Sticky overflow flag, cleared only by reset or flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_ovf <= 1'b0;
    else if (clr_i)              r_ovf <= 1'b0;
    else if (r_s3_vld && w_full) r_ovf <= 1'b1;
  end

  // Issue register: one-cycle strobe, operand and tags hold until the next pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_din_vld  <= 1'b0;
      r_din      <= '0;
      r_tag_idx  <= '0;
      r_tag_last <= 1'b0;
    end else begin
      r_din_vld <= w_pop;
      if (w_pop) begin
        r_din      <= w_head.mag;
        r_tag_idx  <= w_head.idx;
        r_tag_last <= w_head.last;
      end
    end
  end

  // Completion tracking: done_o follows a busy 1->0 edge of an operation we issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_q   <= 1'b0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_busy_q <= bus.sqrt_busy_i;
      r_done   <= w_fall && !clr_i;
      if (clr_i)       r_inflight <= 1'b0;
      else if (w_pop)  r_inflight <= 1'b1;
      else if (w_fall) r_inflight <= 1'b0;
    end
  end

  assign bus.sqrt_din_o       = r_din;
  assign bus.sqrt_din_valid_o = r_din_vld;
  assign bus.tag_idx_o        = r_tag_idx;
  assign bus.tag_last_o       = r_tag_last;
  assign bus.done_o           = r_done;
  assign ovf_o                = r_ovf;
  assign level_o              = w_level;

endmodule

// File: tb/tb_fft_mag_sq_feeder.sv
// Directed bench for fft_mag_sq_feeder with a 16-cycle-busy square-root unit stub.
module tb_fft_mag_sq_feeder;
  import fft_mag_sq_feeder_pkg::*;

  localparam int DEPTH = 8;
  localparam int LW    = 4;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          clr_i      = 1'b0;
  logic          force_busy = 1'b0;
  logic          ovf_o;
  logic [LW-1:0] level_o;

  fft_mag_sq_feeder_if bus();

  fft_mag_sq_feeder #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .clr_i   (clr_i),
    .ovf_o   (ovf_o),
    .level_o (level_o)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int miss = 0;
  int cyc = 0;
  int max_level = 0;
  bit stall_seen = 1'b0;

  typedef struct {
    logic [31:0] mag;
    logic [9:0]  idx;
    logic        last;
    int          cyc;
  } iss_t;

  typedef struct {
    logic [9:0]  idx;
    logic        last;
    logic [15:0] root;
    int          cyc;
  } done_t;

  iss_t  iss_q[$];
  done_t done_q[$];

  function automatic logic [15:0] isqrt(input logic [31:0] x);
    logic [15:0] r;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      longint t;
      t = longint'(r) | (longint'(1) << b);
      if (t * t <= longint'(x)) r = t[15:0];
    end
    return r;
  endfunction

  // Square-root unit stub: busy for 16 cycles after each issue strobe, reset by rst_n
  logic [4:0]  m_cnt;
  logic [15:0] m_root;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= '0;
      m_root <= '0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 5'd1;
    end else if (bus.sqrt_din_valid_o) begin
      m_cnt  <= 5'd16;
      m_root <= isqrt(bus.sqrt_din_o);
    end
  end
  assign bus.sqrt_busy_i = (m_cnt != 0) || force_busy;

  always @(posedge clk) cyc <= cyc + 1;

  // Log issues and completions away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.sqrt_din_valid_o)
        iss_q.push_back('{bus.sqrt_din_o, bus.tag_idx_o, bus.tag_last_o, cyc});
      if (bus.done_o)
        done_q.push_back('{bus.tag_idx_o, bus.tag_last_o, m_root, cyc});
      if (int'(level_o) > max_level) max_level = int'(level_o);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 64'(bus.s_ready_o), 64'd0);
    chk({tag, "_din_vld"}, 64'(bus.sqrt_din_valid_o), 64'd0);
    chk({tag, "_din"}, 64'(bus.sqrt_din_o), 64'd0);
    chk({tag, "_tag_idx"}, 64'(bus.tag_idx_o), 64'd0);
    chk({tag, "_tag_last"}, 64'(bus.tag_last_o), 64'd0);
    chk({tag, "_done"}, 64'(bus.done_o), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf_o), 64'd0);
    chk({tag, "_level"}, 64'(level_o), 64'd0);
  endtask

  task automatic push(input logic signed [15:0] re, input logic signed [15:0] im,
                      input logic [9:0] idx, input logic last);
    int t = 0;
    bus.s_re_i    = re;
    bus.s_im_i    = im;
    bus.s_idx_i   = idx;
    bus.s_last_i  = last;
    bus.s_valid_i = 1'b1;
    if (!bus.s_ready_o) stall_seen = 1'b1;
    while (!bus.s_ready_o && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("push_timeout", 64'd0, 64'd1);
    @(negedge clk);
    bus.s_valid_i = 1'b0;
  endtask

  task automatic wait_iss(input int n);
    int t = 0;
    while (iss_q.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("issue_wait", 64'(iss_q.size() >= n), 64'd1);
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (done_q.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("done_wait", 64'(done_q.size() >= n), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ib;
    int nd;
    bus.s_re_i    = '0;
    bus.s_im_i    = '0;
    bus.s_idx_i   = '0;
    bus.s_last_i  = 1'b0;
    bus.s_valid_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single bin 3-4j: write 3 cycles after transfer, then issue mag 25
    push(16'sd3, -16'sd4, 10'd5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("t1_level_before_write", 64'(level_o), 64'd0);
    @(negedge clk);
    chk("t1_level_at_write", 64'(level_o), 64'd1);
    @(negedge clk);
    chk("t1_issue_vld", 64'(bus.sqrt_din_valid_o), 64'd1);
    chk("t1_issue_mag", 64'(bus.sqrt_din_o), 64'd25);
    chk("t1_issue_idx", 64'(bus.tag_idx_o), 64'd5);
    @(negedge clk);
    chk("t1_strobe_one_cycle", 64'(bus.sqrt_din_valid_o), 64'd0);
    chk("t1_din_hold", 64'(bus.sqrt_din_o), 64'd25);
    wait_done(1);
    repeat (3) @(negedge clk);
    chk("t1_done_count", 64'(done_q.size()), 64'd1);
    chk("t1_done_idx", 64'(done_q[0].idx), 64'd5);
    chk("t1_root", 64'(done_q[0].root), 64'd5);
    chk("t1_done_delay", 64'(done_q[0].cyc - iss_q[0].cyc), 64'd18);

    // Extremes
    push(-16'sd32768, -16'sd32768, 10'd1, 1'b0);
    wait_iss(2);
    chk("t2_max_mag", 64'(iss_q[1].mag), 64'h8000_0000);
    wait_done(2);
    chk("t2_max_root", 64'(done_q[1].root), 64'd46340);
    chk("t2_max_idx", 64'(done_q[1].idx), 64'd1);
    push(16'sd0, 16'sd0, 10'd2, 1'b1);
    wait_iss(3);
    chk("t2_zero_mag", 64'(iss_q[2].mag), 64'd0);
    wait_done(3);
    chk("t2_zero_root", 64'(done_q[2].root), 64'd0);
    chk("t2_zero_last", 64'(done_q[2].last), 64'd1);

    // Burst of 20 back-to-back bins
    stall_seen = 1'b0;
    max_level  = 0;
    for (int i = 0; i < 20; i++)
      push(16'(i), 16'(i + 1), 10'(100 + i), i == 19);
    wait_iss(23);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("t3_idx%0d", i), 64'(iss_q[3 + i].idx), 64'(100 + i));
      chk($sformatf("t3_mag%0d", i), 64'(iss_q[3 + i].mag), 64'(i * i + (i + 1) * (i + 1)));
      chk($sformatf("t3_last%0d", i), 64'(iss_q[3 + i].last), 64'(i == 19));
    end
    chk("t3_ready_dropped", 64'(stall_seen), 64'd1);
    chk("t3_level_bound", 64'(max_level <= DEPTH), 64'd1);
    chk("t3_ovf", 64'(ovf_o), 64'd0);
    wait_done(23);

    // Flush while the sqrt unit is busy: no completion for the flushed bin
    push(16'sd7, 16'sd24, 10'd7, 1'b0);
    wait_iss(24);
    repeat (5) @(negedge clk);
    clr_i = 1'b1;
    #1;
    chk("t4_ready_in_clr", 64'(bus.s_ready_o), 64'd0);
    @(negedge clk);
    clr_i = 1'b0;
    chk("t4_level_after_clr", 64'(level_o), 64'd0);
    chk("t4_ovf_after_clr", 64'(ovf_o), 64'd0);
    nd = done_q.size();
    repeat (30) @(negedge clk);
    chk("t4_no_done", 64'(done_q.size()), 64'(nd));
    push(16'sd6, 16'sd8, 10'd8, 1'b0);
    wait_iss(25);
    chk("t4_next_mag", 64'(iss_q[24].mag), 64'd100);
    wait_done(nd + 1);
    chk("t4_next_idx", 64'(done_q[nd].idx), 64'd8);
    chk("t4_next_root", 64'(done_q[nd].root), 64'd10);

    // Hold busy while filling the FIFO, then release
    force_busy = 1'b1;
    ib = iss_q.size();
    for (int i = 0; i < 8; i++)
      push(16'(i + 1), 16'sd0, 10'(200 + i), i == 7);
    repeat (5) @(negedge clk);
    chk("t5_level_full", 64'(level_o), 64'd8);
    chk("t5_no_issue", 64'(iss_q.size()), 64'(ib));
    chk("t5_ready_low", 64'(bus.s_ready_o), 64'd0);
    force_busy = 1'b0;
    wait_iss(ib + 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t5_idx%0d", i), 64'(iss_q[ib + i].idx), 64'(200 + i));
      chk($sformatf("t5_mag%0d", i), 64'(iss_q[ib + i].mag), 64'((i + 1) * (i + 1)));
      if (i > 0)
        chk($sformatf("t5_gap%0d", i), 64'(iss_q[ib + i].cyc - iss_q[ib + i - 1].cyc >= 2), 64'd1);
    end
    wait_done(nd + 9);

    // Asynchronous reset in the middle of a burst
    ib = iss_q.size();
    for (int i = 0; i < 4; i++)
      push(16'(i + 2), 16'sd0, 10'(300 + i), 1'b0);
    wait_iss(ib + 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    ib = iss_q.size();
    nd = done_q.size();
    push(16'sd5, 16'sd12, 10'd9, 1'b0);
    wait_iss(ib + 1);
    chk("t6_mag", 64'(iss_q[ib].mag), 64'd169);
    wait_done(nd + 1);
    chk("t6_done_idx", 64'(done_q[nd].idx), 64'd9);
    chk("t6_root", 64'(done_q[nd].root), 64'd13);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
